// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory:
// IR fields and status flags in, selects, enables and trap status out.
interface multicycle_ctrl_if;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       InstrDone;
  logic       Fault;

  modport master (
    input  Op, funct3, funct7b5, Zero, MemReady,
    output MemReq, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, Fault
  );

  modport slave (
    output Op, funct3, funct7b5, Zero, MemReady,
    input  MemReq, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, Fault
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (lw, sw, R/I ALU, beq, jal) with a memory
// request/ready handshake, wait-state timeout and an absorbing trap state.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_JAL      = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  localparam int CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } stateT;

  stateT           stateReg, stateNext;
  logic [CntW-1:0] waitCntReg, waitCntNext;

  logic       memReq, adrSrc, irWrite, pcUpdate, branch, memWrite, regWrite, instrDone;
  logic       timeout;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] aluControl, functAlu;

  always_comb begin
    functAlu = 3'b000;
    case (bus.funct3)
      3'b000:  functAlu = (bus.funct7b5 && bus.Op[5]) ? 3'b001 : 3'b000;
      3'b010:  functAlu = 3'b101;
      3'b110:  functAlu = 3'b011;
      3'b111:  functAlu = 3'b010;
      default: functAlu = 3'b000;
    endcase
  end

  // A ready arriving in the same cycle as the limit takes priority over the trap.
  assign timeout = (MEM_TIMEOUT > 0) && (waitCntReg == CntLimit) && !bus.MemReady;

  always_comb begin
    stateNext  = stateReg;
    memReq     = 1'b0;
    adrSrc     = 1'b0;
    irWrite    = 1'b0;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    instrDone  = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    aluControl = 3'b000;
    case (stateReg)
      FETCH: begin
        memReq    = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        if (bus.MemReady) begin
          irWrite   = 1'b1;
          pcUpdate  = 1'b1;
          stateNext = DECODE;
        end else if (timeout) begin
          stateNext = TRAP;
        end
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (bus.Op)
          OpLoad, OpStore: stateNext = MEMADR;
          OpRType:         stateNext = EXECR;
          OpIType:         stateNext = EXECI;
          OpBeq:           stateNext = BEQ;
          OpJal:           stateNext = EN_JAL ? JAL : TRAP;
          default:         stateNext = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        stateNext = (bus.Op == OpLoad) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
        if (bus.MemReady)  stateNext = MEMWB;
        else if (timeout)  stateNext = TRAP;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        stateNext = FETCH;
      end
      MEMWRITE: begin
        memReq   = 1'b1;
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        if (bus.MemReady) begin
          instrDone = 1'b1;
          stateNext = FETCH;
        end else if (timeout) begin
          stateNext = TRAP;
        end
      end
      EXECR: begin
        aluSrcA    = 2'b10;
        aluControl = functAlu;
        stateNext  = ALUWB;
      end
      EXECI: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        aluControl = functAlu;
        stateNext  = ALUWB;
      end
      ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        stateNext = FETCH;
      end
      BEQ: begin
        aluSrcA    = 2'b10;
        aluControl = 3'b001;
        branch     = 1'b1;
        instrDone  = 1'b1;
        stateNext  = FETCH;
      end
      JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        stateNext = ALUWB;
      end
      default: stateNext = TRAP;
    endcase
  end

  // Counter restarts whenever the FSM moves or the memory answers.
  always_comb begin
    waitCntNext = waitCntReg;
    if ((stateNext != stateReg) || bus.MemReady)
      waitCntNext = '0;
    else if (memReq && (waitCntReg != CntLimit))
      waitCntNext = waitCntReg + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= FETCH;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  always_comb begin
    bus.ImmSrc = 2'b00;
    case (bus.Op)
      OpStore: bus.ImmSrc = 2'b01;
      OpBeq:   bus.ImmSrc = 2'b10;
      OpJal:   bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Enables are gated by rst_n so an access is abandoned the moment reset asserts.
  assign bus.MemReq     = rst_n & memReq;
  assign bus.IRWrite    = rst_n & irWrite;
  assign bus.PCWrite    = rst_n & (pcUpdate | (branch & bus.Zero));
  assign bus.MemWrite   = rst_n & memWrite;
  assign bus.RegWrite   = rst_n & regWrite;
  assign bus.InstrDone  = rst_n & instrDone;
  assign bus.AdrSrc     = adrSrc;
  assign bus.ResultSrc  = resultSrc;
  assign bus.ALUSrcA    = aluSrcA;
  assign bus.ALUSrcB    = aluSrcB;
  assign bus.ALUControl = aluControl;
  assign bus.Fault      = (stateReg == TRAP);

endmodule
